// File: rtl/rip_trap_ctrl_if.sv
// Redirect channel from the trap controller to fetch.
// The controller drives the target PC with a valid flag; fetch answers with ready.
interface rip_trap_ctrl_if #(
    parameter int XLEN = 32
);
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            redir_ready;

    modport master (
        output redir_valid,
        output redir_pc,
        input  redir_ready
    );

    modport slave (
        input  redir_valid,
        input  redir_pc,
        output redir_ready
    );
endinterface

// File: rtl/rip_trap_ctrl.sv
// Machine-mode trap sequencer for the RIP core.
// Owns MTVEC/MEPC/MCAUSE, turns exceptions and MRET into a flush pulse followed
// by a held PC redirect to fetch, and stalls the pipeline while that is pending.
module rip_trap_ctrl #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_8000,
    parameter int          XLEN        = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 exc_valid,
    input  logic [4:0]           exc_cause,
    input  logic [XLEN-1:0]      exc_pc,
    input  logic                 mret_valid,
    input  logic [11:0]          csr_addr,
    input  logic                 csr_we,
    input  logic [XLEN-1:0]      csr_wdata,
    output logic [XLEN-1:0]      csr_rdata,
    output logic                 csr_hit,
    output logic                 busy,
    output logic                 flush,
    rip_trap_ctrl_if.master      redir
);

    localparam logic [11:0] ADDR_MTVEC  = 12'h305;
    localparam logic [11:0] ADDR_MEPC   = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE = 12'h342;

    // Clears the two low bits; trap vectors and return PCs are word aligned.
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        REDIR = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] target;
    logic            busy_q;
    logic            flush_q;
    logic            redir_valid_q;
    logic [XLEN-1:0] redir_pc_q;

    logic            trap_take;
    logic            mret_take;
    logic            csr_wr;

    // An exception always wins over a simultaneous MRET or CSR write.
    assign trap_take = (state == IDLE) && exc_valid;
    assign mret_take = (state == IDLE) && !exc_valid && mret_valid;
    assign csr_wr    = (state == IDLE) && !exc_valid && csr_we && csr_hit;

    // Decode the CSR address and return the current register value (no write bypass).
    always_comb begin
        csr_hit   = 1'b0;
        csr_rdata = '0;
        case (csr_addr)
            ADDR_MTVEC:  begin csr_hit = 1'b1; csr_rdata = mtvec;  end
            ADDR_MEPC:   begin csr_hit = 1'b1; csr_rdata = mepc;   end
            ADDR_MCAUSE: begin csr_hit = 1'b1; csr_rdata = mcause; end
            default:     begin csr_hit = 1'b0; csr_rdata = '0;     end
        endcase
    end

    // CSR state: trap entry records the faulting PC and cause, otherwise software writes land.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mtvec  <= RESET_MTVEC;
            mepc   <= '0;
            mcause <= '0;
        end else if (trap_take) begin
            mepc   <= exc_pc & ALIGN_MASK;
            mcause <= {{(XLEN-5){1'b0}}, exc_cause};
        end else if (csr_wr) begin
            case (csr_addr)
                ADDR_MTVEC:  mtvec  <= csr_wdata & ALIGN_MASK;
                ADDR_MEPC:   mepc   <= csr_wdata & ALIGN_MASK;
                ADDR_MCAUSE: mcause <= csr_wdata;
                default:     mcause <= mcause;
            endcase
        end
    end

    // Trap sequencer: latch target, pulse flush, then hold the redirect until fetch accepts it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            target        <= '0;
            busy_q        <= 1'b0;
            flush_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trap_take || mret_take) begin
                        // Target is frozen here so later CSR writes cannot move the redirect.
                        target  <= trap_take ? mtvec : mepc;
                        state   <= FLUSH;
                        busy_q  <= 1'b1;
                        flush_q <= 1'b1;
                    end
                end
                FLUSH: begin
                    state         <= REDIR;
                    flush_q       <= 1'b0;
                    redir_valid_q <= 1'b1;
                    redir_pc_q    <= target;
                end
                REDIR: begin
                    if (redir.redir_ready) begin
                        state         <= IDLE;
                        busy_q        <= 1'b0;
                        redir_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    busy_q        <= 1'b0;
                    flush_q       <= 1'b0;
                    redir_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy              = busy_q;
    assign flush             = flush_q;
    assign redir.redir_valid = redir_valid_q;
    assign redir.redir_pc    = redir_pc_q;

endmodule

// File: tb/tb_rip_trap_ctrl.sv
// Directed bench for rip_trap_ctrl: reset values, ECALL/illegal/MRET sequences,
// redirect backpressure, trap/CSR collisions and reset in the middle of a redirect.
module tb_rip_trap_ctrl;

    logic        clk;
    logic        rstn;
    logic        exc_valid;
    logic [4:0]  exc_cause;
    logic [31:0] exc_pc;
    logic        mret_valid;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_hit;
    logic        busy;
    logic        flush;

    int n_assert = 0;
    int n_fail   = 0;

    rip_trap_ctrl_if #(.XLEN(32)) rif ();

    rip_trap_ctrl #(
        .RESET_MTVEC (32'h0000_8000),
        .XLEN        (32)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .exc_valid  (exc_valid),
        .exc_cause  (exc_cause),
        .exc_pc     (exc_pc),
        .mret_valid (mret_valid),
        .csr_addr   (csr_addr),
        .csr_we     (csr_we),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .csr_hit    (csr_hit),
        .busy       (busy),
        .flush      (flush),
        .redir      (rif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Combinational CSR read, taken between clock edges.
    task automatic rd(input logic [11:0] addr, output logic [31:0] val);
        csr_addr = addr;
        #1;
        val = csr_rdata;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        csr_addr  = addr;
        csr_we    = 1'b1;
        csr_wdata = data;
        tick();
        csr_we    = 1'b0;
    endtask

    logic [31:0] v;

    initial begin
        rstn       = 1'b0;
        exc_valid  = 1'b0;
        exc_cause  = '0;
        exc_pc     = '0;
        mret_valid = 1'b0;
        csr_addr   = '0;
        csr_we     = 1'b0;
        csr_wdata  = '0;
        rif.redir_ready = 1'b1;

        // Reset
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        rd(12'h305, v); check("rst_mtvec", v, 32'h0000_8000);
        check("rst_hit_mtvec", {31'b0, csr_hit}, 32'd1);
        rd(12'h341, v); check("rst_mepc", v, 32'h0);
        rd(12'h342, v); check("rst_mcause", v, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_redir_valid", {31'b0, rif.redir_valid}, 32'd0);
        check("rst_flush", {31'b0, flush}, 32'd0);

        // ECALL with fetch always ready
        exc_valid = 1'b1; exc_cause = 5'd11; exc_pc = 32'h0000_8010;
        tick();
        exc_valid = 1'b0;
        check("ecall_flush", {31'b0, flush}, 32'd1);
        check("ecall_busy1", {31'b0, busy}, 32'd1);
        check("ecall_rv1", {31'b0, rif.redir_valid}, 32'd0);
        rd(12'h341, v); check("ecall_mepc", v, 32'h0000_8010);
        rd(12'h342, v); check("ecall_mcause", v, 32'd11);
        tick();
        check("ecall_flush2", {31'b0, flush}, 32'd0);
        check("ecall_rv2", {31'b0, rif.redir_valid}, 32'd1);
        check("ecall_rpc", rif.redir_pc, 32'h0000_8000);
        check("ecall_busy2", {31'b0, busy}, 32'd1);
        tick();
        check("ecall_rv3", {31'b0, rif.redir_valid}, 32'd0);
        check("ecall_busy3", {31'b0, busy}, 32'd0);

        // MTVEC write with low bits set
        wr(12'h305, 32'h0000_9003);
        rd(12'h305, v); check("mtvec_wr", v, 32'h0000_9000);

        // Illegal instruction
        exc_valid = 1'b1; exc_cause = 5'd2; exc_pc = 32'h0000_8020;
        tick();
        exc_valid = 1'b0;
        check("ill_flush", {31'b0, flush}, 32'd1);
        tick();
        check("ill_rv", {31'b0, rif.redir_valid}, 32'd1);
        check("ill_rpc", rif.redir_pc, 32'h0000_9000);
        rd(12'h342, v); check("ill_mcause", v, 32'd2);
        rd(12'h341, v); check("ill_mepc", v, 32'h0000_8020);
        tick();
        check("ill_busy_end", {31'b0, busy}, 32'd0);

        // Software sets MEPC (low bits dropped), then MRET
        wr(12'h341, 32'h0000_8027);
        rd(12'h341, v); check("mepc_wr", v, 32'h0000_8024);
        mret_valid = 1'b1;
        tick();
        mret_valid = 1'b0;
        check("mret_flush", {31'b0, flush}, 32'd1);
        rd(12'h342, v); check("mret_mcause_kept", v, 32'd2);
        tick();
        check("mret_rv", {31'b0, rif.redir_valid}, 32'd1);
        check("mret_rpc", rif.redir_pc, 32'h0000_8024);
        tick();
        check("mret_busy_end", {31'b0, busy}, 32'd0);

        // Backpressure; a CSR write attempted while busy must be dropped
        rif.redir_ready = 1'b0;
        exc_valid = 1'b1; exc_cause = 5'd11; exc_pc = 32'h0000_8030;
        tick();
        exc_valid = 1'b0;
        tick();
        csr_addr = 12'h305; csr_we = 1'b1; csr_wdata = 32'h0000_A000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rv", {31'b0, rif.redir_valid}, 32'd1);
            check("bp_rpc", rif.redir_pc, 32'h0000_9000);
            check("bp_busy", {31'b0, busy}, 32'd1);
        end
        csr_we = 1'b0;
        rd(12'h305, v); check("bp_mtvec_kept", v, 32'h0000_9000);
        rif.redir_ready = 1'b1;
        tick();
        check("bp_rv_end", {31'b0, rif.redir_valid}, 32'd0);
        check("bp_busy_end", {31'b0, busy}, 32'd0);

        // Exception and MRET together: exception path, redirect to MTVEC
        exc_valid = 1'b1; mret_valid = 1'b1; exc_cause = 5'd2; exc_pc = 32'h0000_8042;
        tick();
        exc_valid = 1'b0; mret_valid = 1'b0;
        rd(12'h341, v); check("col_mepc", v, 32'h0000_8040);
        tick();
        check("col_rpc", rif.redir_pc, 32'h0000_9000);
        tick();

        // Exception and MEPC write together: trap update wins
        exc_valid = 1'b1; exc_cause = 5'd11; exc_pc = 32'h0000_8050;
        csr_addr = 12'h341; csr_we = 1'b1; csr_wdata = 32'h0000_1234;
        tick();
        exc_valid = 1'b0; csr_we = 1'b0;
        rd(12'h341, v); check("colw_mepc", v, 32'h0000_8050);
        tick();
        tick();
        check("colw_busy_end", {31'b0, busy}, 32'd0);

        // Unsupported CSR address
        csr_addr = 12'h300;
        #1;
        check("unsup_hit", {31'b0, csr_hit}, 32'd0);
        check("unsup_rdata", csr_rdata, 32'h0);
        wr(12'h300, 32'hFFFF_FFFF);
        rd(12'h305, v); check("unsup_mtvec", v, 32'h0000_9000);
        rd(12'h341, v); check("unsup_mepc", v, 32'h0000_8050);
        rd(12'h342, v); check("unsup_mcause", v, 32'd11);

        // MCAUSE is written in full
        wr(12'h342, 32'h8000_0007);
        rd(12'h342, v); check("mcause_full", v, 32'h8000_0007);

        // Reset during REDIR
        rif.redir_ready = 1'b0;
        exc_valid = 1'b1; exc_cause = 5'd11; exc_pc = 32'h0000_8060;
        tick();
        exc_valid = 1'b0;
        tick();
        check("mid_rv_before", {31'b0, rif.redir_valid}, 32'd1);
        rstn = 1'b0;
        #1;
        check("mid_rv", {31'b0, rif.redir_valid}, 32'd0);
        check("mid_busy", {31'b0, busy}, 32'd0);
        check("mid_flush", {31'b0, flush}, 32'd0);
        check("mid_rpc", rif.redir_pc, 32'h0);
        rd(12'h305, v); check("mid_mtvec", v, 32'h0000_8000);
        rd(12'h341, v); check("mid_mepc", v, 32'h0);
        tick();
        rstn = 1'b1;
        rif.redir_ready = 1'b1;
        tick();
        check("post_rst_busy", {31'b0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rip_trap_ctrl.md
Name: rip_trap_ctrl

Overview:
Machine-mode trap sequencer for the RIP core. Owns the MTVEC (0x305), MEPC (0x341) and MCAUSE (0x342) CSRs. On an exception (illegal instruction, cause 2; ECALL, cause 11) or an MRET it flushes the pipeline and issues a PC redirect to fetch over a valid/ready handshake. Sits between decode/execute (trap sources, CSR access) and the fetch stage.

Parameters:
RESET_MTVEC, 32'h00008000, reset value of MTVEC (START_ADDR); bits [1:0] must be 0
XLEN, 32, data and address width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
exc_valid  in  1  exception request from execute, single-cycle pulse
exc_cause  in  5  exception code (2 = illegal instruction, 11 = ECALL)
exc_pc  in  XLEN  PC of the faulting instruction
mret_valid  in  1  MRET retire pulse
csr_addr  in  12  CSR address for read/write
csr_we  in  1  CSR write enable
csr_wdata  in  XLEN  CSR write data
csr_rdata  out  XLEN  CSR read data, combinational
csr_hit  out  1  csr_addr is 0x305, 0x341 or 0x342, combinational
busy  out  1  trap sequence in progress; pipeline must stall
flush  out  1  one-cycle pulse; kill all younger in-flight instructions
redir_valid  out  1  redirect request to fetch
redir_pc  out  XLEN  redirect target
redir_ready  in  1  fetch accepts redirect

Behaviour:
- Reset (rstn low, async): state IDLE; MTVEC = RESET_MTVEC, MEPC = 0, MCAUSE = 0; busy, flush and redir_valid = 0; redir_pc = 0.
- FSM states: IDLE, FLUSH, REDIR.
- IDLE, exc_valid=1: in the same clock edge, MEPC <= {exc_pc[31:2],2'b00} and MCAUSE <= {27'b0, exc_cause} (bit 31 = 0). Target latched as MTVEC. Next state FLUSH.
- IDLE, mret_valid=1 and exc_valid=0: target latched as MEPC. CSRs unchanged. Next state FLUSH.
- Both exc_valid and mret_valid in the same cycle: exception wins and MRET is ignored.
- FLUSH: flush=1 and busy=1 for exactly one cycle; next state REDIR.
- REDIR: busy=1, redir_valid=1, redir_pc = latched target. Hold until redir_ready=1 is sampled, then return to IDLE. busy drops in the same cycle that redir_valid drops.
- Latency: trap pulse at edge N gives flush at N+1 and redir_valid from N+2. With redir_ready tied high, the controller is back in IDLE at N+3.
- exc_valid or mret_valid while not in IDLE is ignored. Upstream guarantees none arrive because busy is stalling.
- CSR write (csr_we=1, csr_hit=1, IDLE, exc_valid=0): takes effect at the next edge.
  - MTVEC and MEPC bits [1:0] are forced to 0.
  - MCAUSE is written in full.
- CSR writes are dropped when busy=1 or exc_valid=1; the trap update has priority.
- CSR writes to unsupported addresses are dropped; csr_hit=0.
- csr_rdata returns the current register value; it reads 0 when csr_hit=0. It is combinational from the registers, with no bypass of a same-cycle write.
- The redirect target is captured at trap entry. Later MTVEC/MEPC values do not alter an in-flight redirect.
- Reset asserted mid-sequence returns to IDLE immediately, with all outputs at reset values.

Test Plan:
- Reset: release rstn -> MTVEC reads 0x00008000; MEPC and MCAUSE read 0; busy=0, redir_valid=0.
- ECALL: exc_valid, cause 11, exc_pc 0x00008010, redir_ready=1 -> flush pulse at +1; redir_valid with redir_pc 0x00008000 at +2; MEPC=0x00008010; MCAUSE=11; IDLE at +3.
- Illegal instruction then MRET:
  - Write MTVEC=0x00009003 -> reads 0x00009000.
  - exc_valid, cause 2, exc_pc 0x00008020 -> redirect to 0x00009000.
  - Software writes MEPC=0x00008024; mret_valid -> redir_pc 0x00008024.
- Backpressure: hold redir_ready=0 for 5 cycles during REDIR -> redir_valid, redir_pc and busy stay stable; one cycle after ready=1, busy=0.
- Collisions:
  - exc_valid and mret_valid together -> exception path taken; MEPC updated.
  - exc_valid with csr_we to MEPC=0x1234 -> MEPC holds exc_pc.
  - csr_we to 0x300 -> csr_hit=0, csr_rdata=0, no state change.
- Reset mid-sequence: pull rstn low during REDIR -> redir_valid=0 and busy=0 at once; MTVEC back to 0x00008000.
